// File: rtl/jtag_tap_regs.sv
// JTAG instruction register and BYPASS/IDCODE/USER data registers.
// Driven by the one-hot TAP state outputs; produces TDO/TDO_OE.
module jtag_tap_regs #(
    parameter int                     IR_WIDTH     = 4,
    parameter int                     DR_WIDTH     = 16,
    parameter logic [31:0]            IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE    = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0]    OP_USER      = IR_WIDTH'(4'b0010),
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS    = IR_WIDTH'(4'b1111)
) (
    input  logic                TCK,
    input  logic                TRST_N,
    input  logic                TDI,
    input  logic                test_logic_reset,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic [DR_WIDTH-1:0] user_dr_in,
    output logic                TDO,
    output logic                TDO_OE,
    output logic [IR_WIDTH-1:0] ir_q,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                user_update
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_sr;
    logic [31:0]         idcode_sr;
    logic [DR_WIDTH-1:0] user_sr;

    logic sel_idcode, sel_user, sel_bypass;
    logic cap_any, shf_any;
    logic do_cap_ir, do_cap_dr;
    logic do_shift_ir, do_shift_dr;
    logic do_upd_ir, do_upd_dr;

    // Resolve illegal multi-state combinations: reset > capture > shift > update.
    assign cap_any     = capture_ir | capture_dr;
    assign shf_any     = shift_ir | shift_dr;
    assign do_cap_ir   = ~test_logic_reset & capture_ir;
    assign do_cap_dr   = ~test_logic_reset & capture_dr;
    assign do_shift_ir = ~test_logic_reset & ~cap_any & shift_ir;
    assign do_shift_dr = ~test_logic_reset & ~cap_any & shift_dr;
    assign do_upd_ir   = ~test_logic_reset & ~cap_any & ~shf_any & update_ir;
    assign do_upd_dr   = ~test_logic_reset & ~cap_any & ~shf_any & update_dr;

    always_comb begin
        sel_idcode = 1'b0;
        sel_user   = 1'b0;
        sel_bypass = 1'b0;
        unique case (1'b1)
            (ir_q == OP_IDCODE): sel_idcode = 1'b1;
            (ir_q == OP_USER):   sel_user   = 1'b1;
            default:             sel_bypass = 1'b1;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift <= IR_CAPTURE;
            ir_q     <= OP_IDCODE;
        end else if (test_logic_reset) begin
            ir_shift <= IR_CAPTURE;
            ir_q     <= OP_IDCODE;
        end else if (do_cap_ir) begin
            ir_shift <= IR_CAPTURE;
        end else if (do_shift_ir) begin
            ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        end else if (do_upd_ir) begin
            ir_q <= ir_shift;
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_sr   <= 1'b0;
            idcode_sr   <= '0;
            user_sr     <= '0;
            user_dr_out <= '0;
            user_update <= 1'b0;
        end else if (test_logic_reset) begin
            bypass_sr   <= 1'b0;
            idcode_sr   <= '0;
            user_sr     <= '0;
            user_dr_out <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= do_upd_dr & sel_user;
            if (do_cap_dr) begin
                if (sel_bypass) bypass_sr <= 1'b0;
                if (sel_idcode) idcode_sr <= IDCODE_VALUE;
                if (sel_user)   user_sr   <= user_dr_in;
            end else if (do_shift_dr) begin
                if (sel_bypass) bypass_sr <= TDI;
                if (sel_idcode) idcode_sr <= {TDI, idcode_sr[31:1]};
                if (sel_user)   user_sr   <= {TDI, user_sr[DR_WIDTH-1:1]};
            end
            if (do_upd_dr && sel_user) user_dr_out <= user_sr;
        end
    end

    always_comb begin
        TDO    = 1'b0;
        TDO_OE = 1'b0;
        if (TRST_N) begin
            if (do_shift_ir) begin
                TDO    = ir_shift[0];
                TDO_OE = 1'b1;
            end else if (do_shift_dr) begin
                TDO_OE = 1'b1;
                unique case (1'b1)
                    sel_idcode: TDO = idcode_sr[0];
                    sel_user:   TDO = user_sr[0];
                    default:    TDO = bypass_sr;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Directed self-checking bench for jtag_tap_regs.
// Drives TAP state one-hots per TCK and checks TDO and register outputs.
module tb_jtag_tap_regs;

    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_TLR  = 7'b1000000;
    localparam logic [6:0] S_CDR  = 7'b0100000;
    localparam logic [6:0] S_SDR  = 7'b0010000;
    localparam logic [6:0] S_UDR  = 7'b0001000;
    localparam logic [6:0] S_CIR  = 7'b0000100;
    localparam logic [6:0] S_SIR  = 7'b0000010;
    localparam logic [6:0] S_UIR  = 7'b0000001;

    logic        TCK = 1'b0;
    logic        TRST_N;
    logic        TDI;
    logic        test_logic_reset, capture_dr, shift_dr, update_dr;
    logic        capture_ir, shift_ir, update_ir;
    logic [15:0] user_dr_in;
    logic        TDO, TDO_OE;
    logic [3:0]  ir_q;
    logic [15:0] user_dr_out;
    logic        user_update;

    int checks = 0;
    int failures = 0;

    always #5 TCK = ~TCK;

    jtag_tap_regs dut (
        .TCK              (TCK),
        .TRST_N           (TRST_N),
        .TDI              (TDI),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir),
        .user_dr_in       (user_dr_in),
        .TDO              (TDO),
        .TDO_OE           (TDO_OE),
        .ir_q             (ir_q),
        .user_dr_out      (user_dr_out),
        .user_update      (user_update)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_state(input logic [6:0] st, input logic tdi);
        {test_logic_reset, capture_dr, shift_dr, update_dr,
         capture_ir, shift_ir, update_ir} = st;
        TDI = tdi;
    endtask

    // Hold a state for one TCK; sample outputs at the falling edge.
    task automatic tick(input logic [6:0] st, input logic tdi,
                        output logic tdo_o, output logic oe_o);
        set_state(st, tdi);
        @(negedge TCK);
        tdo_o = TDO;
        oe_o  = TDO_OE;
        @(posedge TCK);
        #1;
    endtask

    task automatic ir_scan(input logic [3:0] val, output logic [3:0] cap);
        logic t, o;
        cap = '0;
        tick(S_CIR, 1'b0, t, o);
        for (int i = 0; i < 4; i++) begin
            tick(S_SIR, val[i], t, o);
            cap[i] = t;
        end
        tick(S_UIR, 1'b0, t, o);
        tick(S_IDLE, 1'b0, t, o);
    endtask

    // Capture then shift n bits; oe_ok is 1 if OE was low on capture and high on all shifts.
    task automatic dr_shift(input int n, input logic [31:0] val,
                            output logic [31:0] out, output logic oe_ok);
        logic t, o;
        out = '0;
        tick(S_CDR, 1'b0, t, o);
        oe_ok = ~o;
        for (int i = 0; i < n; i++) begin
            tick(S_SDR, val[i], t, o);
            out[i] = t;
            oe_ok  = oe_ok & o;
        end
    endtask

    logic        t, o, ok;
    logic [3:0]  cap;
    logic [31:0] out;

    initial begin
        TRST_N = 1'b0;
        user_dr_in = '0;
        set_state(S_IDLE, 1'b0);
        repeat (3) @(posedge TCK);
        #2;
        chk("rst_ir_q", 32'(ir_q), 32'h1);
        chk("rst_tdo", 32'(TDO), 32'h0);
        chk("rst_tdo_oe", 32'(TDO_OE), 32'h0);
        chk("rst_user_dr_out", 32'(user_dr_out), 32'h0);
        chk("rst_user_update", 32'(user_update), 32'h0);
        @(negedge TCK);
        TRST_N = 1'b1;
        @(posedge TCK);
        #1;

        // IDCODE selected out of reset
        dr_shift(32, 32'h0, out, ok);
        tick(S_UDR, 1'b0, t, o);
        ok = ok & ~o;
        chk("idcode_tdo", out, 32'h1000_0001);
        chk("idcode_oe", 32'(ok), 32'h1);

        // BYPASS via explicit opcode
        ir_scan(4'b1111, cap);
        chk("ir_capture_tdo", 32'(cap), 32'h1);
        chk("ir_q_bypass", 32'(ir_q), 32'hF);
        dr_shift(4, 32'hD, out, ok);
        tick(S_UDR, 1'b0, t, o);
        chk("bypass_delay", out, 32'hA);

        // USER read/write
        ir_scan(4'b0010, cap);
        chk("ir_q_user", 32'(ir_q), 32'h2);
        user_dr_in = 16'hA5C3;
        dr_shift(16, 32'h1234, out, ok);
        chk("user_tdo", out, 32'hA5C3);
        chk("user_update_pre", 32'(user_update), 32'h0);
        tick(S_UDR, 1'b0, t, o);
        chk("user_update_pulse", 32'(user_update), 32'h1);
        chk("user_dr_out", 32'(user_dr_out), 32'h1234);
        tick(S_IDLE, 1'b0, t, o);
        chk("user_update_post", 32'(user_update), 32'h0);

        // Undefined opcode decodes to BYPASS
        ir_scan(4'b0110, cap);
        chk("ir_q_undef", 32'(ir_q), 32'h6);
        dr_shift(16, 32'hFFFF, out, ok);
        tick(S_UDR, 1'b0, t, o);
        chk("undef_tdo", out, 32'hFFFE);
        chk("undef_no_update", 32'(user_update), 32'h0);
        chk("undef_dr_out_hold", 32'(user_dr_out), 32'h1234);

        // USER scan with Pause_DR after 8 bits
        ir_scan(4'b0010, cap);
        user_dr_in = 16'h0F0F;
        dr_shift(8, 32'h00EF, out, ok);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(S_IDLE, 1'b1, t, o);
            ok = ok & ~o;
        end
        chk("pause_oe_low", 32'(ok), 32'h1);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'hBEEF;
            tick(S_SDR, v[8+i], t, o);
            out[8+i] = t;
        end
        chk("pause_tdo", out, 32'h0F0F);
        tick(S_UDR, 1'b0, t, o);
        chk("pause_dr_out", 32'(user_dr_out), 32'hBEEF);

        // Synchronous Test_Logic_Reset
        tick(S_TLR, 1'b0, t, o);
        chk("tlr_ir_q", 32'(ir_q), 32'h1);
        chk("tlr_dr_out", 32'(user_dr_out), 32'h0);

        // TRST_N mid USER shift
        ir_scan(4'b0010, cap);
        user_dr_in = 16'h5555;
        dr_shift(5, 32'h1F, out, ok);
        set_state(S_SDR, 1'b1);
        TRST_N = 1'b0;
        #1;
        chk("trst_ir_q", 32'(ir_q), 32'h1);
        chk("trst_dr_out", 32'(user_dr_out), 32'h0);
        chk("trst_update", 32'(user_update), 32'h0);
        chk("trst_tdo", 32'(TDO), 32'h0);
        chk("trst_tdo_oe", 32'(TDO_OE), 32'h0);
        @(negedge TCK);
        TRST_N = 1'b1;
        @(posedge TCK);
        #1;
        tick(S_UDR, 1'b0, t, o);
        chk("trst_udr_dr_out", 32'(user_dr_out), 32'h0);
        chk("trst_udr_update", 32'(user_update), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
